l1_port_arbiter: RTL
====================

// Module: l1_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single L1 data-cache request port among N_REQ requesters
//  (traffic generators / core ports). It holds at most one transaction in flight, routes the
//  cache response back to the owner, and flags protocol faults (spurious response, timeout).
//  It sits between the requesters and the l1 cache top; every side uses the valid/stall/resp_valid handshake.
// PARAMETERS
//  N_REQ        4    number of requesters, legal 2..8; IDX_W = $clog2(N_REQ)
//  TIMEOUT_CYC  255  max cycles in WAIT before abort, legal 1..65535
// PORTS
//  clk            in   1         clock, all logic on posedge
//  rst_n          in   1         asynchronous active-low reset
//  rq_valid       in   N_REQ     per-requester request valid
//  rq_we          in   N_REQ     per-requester write enable
//  rq_addr        in   32*N_REQ  per-requester address, requester i at [32*i +: 32]
//  rq_wdata       in   32*N_REQ  per-requester write data
//  rq_wstrb       in   4*N_REQ   per-requester byte strobes
//  rq_stall       out  N_REQ     per-requester stall; low = request accepted this cycle
//  rq_resp_valid  out  N_REQ     one-hot response strobe to the owner
//  rq_resp_rdata  out  32        shared response data, valid with rq_resp_valid
//  req_valid/req_we/req_addr/req_wdata/req_wstrb  out 1/1/32/32/4  to cache
//  resp_stall     in   1         cache stall
//  resp_valid     in   1         cache response valid
//  resp_rdata     in   32        cache response data
//  err_spurious   out  1         sticky: resp_valid seen outside WAIT
//  err_timeout    out  1         sticky: WAIT exceeded TIMEOUT_CYC
//  perf_clr       in   1         clear performance counters (see CONFIGURATION)
//  perf_done_cnt  out  16*N_REQ  per-requester completed-transaction count
//  perf_stall_cnt out  32        cycles in GRANT with resp_stall=1
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, rr_ptr=0, wait_cnt=0, errors=0. All outputs are 0 except rq_stall, which is all-ones.
//  FSM, all state registered:
//  - IDLE: req_valid=0. If |rq_valid: owner <= first set index scanning rr_ptr, rr_ptr+1, ... mod N_REQ; go to GRANT.
//  - GRANT: req_* = owner's fields, req_valid = rq_valid[owner].
//    - If rq_valid[owner]=0 (requester withdrew): go to IDLE, rr_ptr unchanged.
//    - Else if !resp_stall: the request is accepted; go to WAIT with wait_cnt=0.
//    - Else stay in GRANT; owner stays locked, so no requester can steal the port mid-stall.
//  - WAIT: req_valid=0; wait_cnt increments each cycle.
//    - If resp_valid: rq_resp_valid[owner]=1 and rq_resp_rdata=resp_rdata combinationally (same cycle);
//      rr_ptr <= (owner==N_REQ-1) ? 0 : owner+1; go to IDLE.
//    - Else if wait_cnt==TIMEOUT_CYC-1: set err_timeout, update rr_ptr as above, go to IDLE.
//      The owner gets no response.
//  - rq_stall[i] = ~(state==GRANT && owner==i && rq_valid[i] && !resp_stall); combinational.
//  - resp_valid in IDLE/GRANT: ignored, not forwarded; set err_spurious.
//    This includes a late response after a timeout.
//  - Errors are cleared only by reset.
//  Latency and throughput: rq_valid rising -> req_valid after 1 cycle (IDLE->GRANT).
//  Minimum transaction is 3 cycles: IDLE, GRANT, WAIT with a 1-cycle cache response.
//  rq_resp_rdata is 0 when no rq_resp_valid bit is set.
//  Simultaneous requests: the lowest index at or after rr_ptr wins. A requester
//  that is served drops to lowest priority.
//  Reset mid-transaction: FSM returns to IDLE immediately; the in-flight cache response is not tracked.
// CONFIGURATION
//  Macro L1_ARB_PERF_EN:
//  - Defined: perf_done_cnt[i] +1 on each response delivered to requester i.
//    perf_stall_cnt +1 each GRANT cycle with resp_stall=1.
//    Both counters saturate at all-ones. perf_clr=1 zeroes both next cycle; clear has priority over increment.
//    Reset value is 0.
//  - Undefined: counters are not built; perf_done_cnt and perf_stall_cnt are tied to 0 and perf_clr is ignored.
// TESTING
//  1. Single request: rq_valid=0001, addr 0x1000, we=1, wdata 0xA5A50000.
//     -> req_valid next cycle with the same fields; rq_stall[0]=0 that cycle.
//     -> Cache resp_valid after 1 cycle gives rq_resp_valid=0001.
//  2. Contention: rq_valid=1111 held.
//     -> Grant order 0,1,2,3,0; each owner's address appears on req_addr in turn.
//     -> No two responses go to the same requester back-to-back.
//  3. Stall lock: owner=2 in GRANT, resp_stall=1 for 5 cycles while rq_valid[0] is asserted.
//     -> req_addr stays at requester 2's address.
//     -> Accept on cycle 6; perf_stall_cnt=5 (with L1_ARB_PERF_EN).
//  4. Timeout: TIMEOUT_CYC=8, accepted request with no resp_valid.
//     -> err_timeout=1 after 8 WAIT cycles; FSM in IDLE.
//     -> resp_valid arriving later sets err_spurious; rq_resp_valid stays 0.
//  5. Withdraw: rq_valid[1] drops while in GRANT with resp_stall=1.
//     -> Next state IDLE; rr_ptr unchanged; no req is accepted.
//  6. Reset mid-WAIT: rst_n=0.
//     -> rq_stall=all-ones, req_valid=0, errors=0, perf counters=0.
//     -> After release, a new request is served normally.

Source files
------------

// File: rtl/l1_port_arbiter.sv
// Round-robin arbiter sharing one L1 cache request port among N_REQ requesters, one transaction in flight.
// Define L1_ARB_PERF_EN to build the per-requester done counters and the GRANT-stall counter.
module l1_port_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    rq_valid,
   input  logic [N_REQ-1:0]    rq_we,
   input  logic [32*N_REQ-1:0] rq_addr,
   input  logic [32*N_REQ-1:0] rq_wdata,
   input  logic [4*N_REQ-1:0]  rq_wstrb,
   output logic [N_REQ-1:0]    rq_stall,
   output logic [N_REQ-1:0]    rq_resp_valid,
   output logic [31:0]         rq_resp_rdata,
   output logic                req_valid,
   output logic                req_we,
   output logic [31:0]         req_addr,
   output logic [31:0]         req_wdata,
   output logic [3:0]          req_wstrb,
   input  logic                resp_stall,
   input  logic                resp_valid,
   input  logic [31:0]         resp_rdata,
   output logic                err_spurious,
   output logic                err_timeout,
   input  logic                perf_clr,
   output logic [16*N_REQ-1:0] perf_done_cnt,
   output logic [31:0]         perf_stall_cnt
);
   localparam int          IDX_W     = $clog2(N_REQ);
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, rr_after_owner, cand;
   logic [15:0]      wait_cnt, wait_cnt_nxt;
   logic             set_spurious, set_timeout, deliver, found;
   int               cand_int;

   assign rr_after_owner = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= '0;
         rr_ptr       <= '0;
         wait_cnt     <= '0;
         err_spurious <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         rr_ptr       <= rr_ptr_nxt;
         wait_cnt     <= wait_cnt_nxt;
         err_spurious <= err_spurious | set_spurious;
         err_timeout  <= err_timeout | set_timeout;
      end
   end

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      rr_ptr_nxt    = rr_ptr;
      wait_cnt_nxt  = wait_cnt;
      set_spurious  = resp_valid && (state != WAIT);
      set_timeout   = 1'b0;
      deliver       = 1'b0;
      found         = 1'b0;
      cand          = '0;
      cand_int      = 0;
      rq_stall      = '1;
      rq_resp_valid = '0;
      rq_resp_rdata = '0;
      req_valid     = 1'b0;
      req_we        = 1'b0;
      req_addr      = '0;
      req_wdata     = '0;
      req_wstrb     = '0;
      case (state)
         IDLE: begin
            // First valid requester at or after rr_ptr, wrapping modulo N_REQ
            for (int k = 0; k < N_REQ; k++) begin
               cand_int = int'(rr_ptr) + k;
               if (cand_int >= N_REQ) cand_int = cand_int - N_REQ;
               cand = IDX_W'(cand_int);
               if (!found && rq_valid[cand]) begin
                  found     = 1'b1;
                  owner_nxt = cand;
               end
            end
            if (found) state_nxt = GRANT;
         end
         GRANT: begin
            req_valid = rq_valid[owner];
            req_we    = rq_we[owner];
            req_addr  = rq_addr[32*owner +: 32];
            req_wdata = rq_wdata[32*owner +: 32];
            req_wstrb = rq_wstrb[4*owner +: 4];
            if (!rq_valid[owner]) begin
               state_nxt = IDLE;
            end else if (!resp_stall) begin
               rq_stall[owner] = 1'b0;
               wait_cnt_nxt    = '0;
               state_nxt       = WAIT;
            end
         end
         WAIT: begin
            wait_cnt_nxt = wait_cnt + 16'd1;
            if (resp_valid) begin
               deliver              = 1'b1;
               rq_resp_valid[owner] = 1'b1;
               rq_resp_rdata        = resp_rdata;
               rr_ptr_nxt           = rr_after_owner;
               state_nxt            = IDLE;
            end else if (wait_cnt == WAIT_LAST) begin
               set_timeout = 1'b1;
               rr_ptr_nxt  = rr_after_owner;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef L1_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_done_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else if (perf_clr) begin
         perf_done_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (deliver && perf_done_cnt[16*owner +: 16] != 16'hFFFF)
            perf_done_cnt[16*owner +: 16] <= perf_done_cnt[16*owner +: 16] + 16'd1;
         if (state == GRANT && resp_stall && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   logic unused_perf;

   assign perf_done_cnt  = '0;
   assign perf_stall_cnt = '0;
   // Counter inputs have no sink when the counters are not built
   assign unused_perf    = perf_clr ^ deliver;
`endif

endmodule
